// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// imuldiv_muldiv_dispatch_pkg: request encodings and tag type shared by the mul/div dispatch front end
package imuldiv_muldiv_dispatch_pkg;
   localparam logic [2:0] FN_MUL  = 3'd0;
   localparam logic [2:0] FN_DIV  = 3'd1;
   localparam logic [2:0] FN_DIVU = 3'd2;
   localparam logic [2:0] FN_REM  = 3'd3;
   localparam logic [2:0] FN_REMU = 3'd4;
   localparam logic DIVFN_SIGNED   = 1'b0;
   localparam logic DIVFN_UNSIGNED = 1'b1;
   typedef enum logic {TAG_MUL = 1'b0, TAG_DIV = 1'b1} tag_e;
   function automatic logic is_div_fn(input logic [2:0] fn);
      return fn >= FN_DIV && fn <= FN_REMU;
   endfunction
   function automatic logic is_unsigned_fn(input logic [2:0] fn);
      return fn == FN_DIVU || fn == FN_REMU;
   endfunction
endpackage

// File: rtl/imuldiv_muldiv_dispatch_tagfifo.sv
// imuldiv_TagFifo: 1-bit tag FIFO remembering which unit owns each in-flight request
module imuldiv_TagFifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enq_val,
   input  logic enq_bits,
   input  logic deq_rdy,
   output logic full,
   output logic empty,
   output logic head_bits
);
   localparam int AW = $clog2(DEPTH);
   logic [DEPTH-1:0] mem;
   logic [AW-1:0] head, tail;
   logic [AW:0] count;
   logic enq, deq;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign enq = enq_val && !full;
   assign deq = deq_rdy && !empty;
   assign head_bits = mem[head];
   // pointers wrap naturally at DEPTH; count tracks occupancy through simultaneous push/pop
   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            mem[tail] <= enq_bits;
            tail <= tail + 1'b1;
         end
         if (deq) head <= head + 1'b1;
         count <= count + (AW+1)'(enq) - (AW+1)'(deq);
      end
   end
endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// imuldiv_muldiv_dispatch: routes mul/div requests to the iterative units and returns results in order
import imuldiv_muldiv_dispatch_pkg::*;
module imuldiv_muldiv_dispatch #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  muldivreq_msg_fn,
   input  logic [31:0] muldivreq_msg_a,
   input  logic [31:0] muldivreq_msg_b,
   input  logic        muldivreq_val,
   output logic        muldivreq_rdy,
   output logic [63:0] muldivresp_msg_result,
   output logic        muldivresp_val,
   input  logic        muldivresp_rdy,
   output logic [31:0] mulreq_msg_a,
   output logic [31:0] mulreq_msg_b,
   output logic        mulreq_val,
   input  logic        mulreq_rdy,
   input  logic [63:0] mulresp_msg_result,
   input  logic        mulresp_val,
   output logic        mulresp_rdy,
   output logic        divreq_msg_fn,
   output logic [31:0] divreq_msg_a,
   output logic [31:0] divreq_msg_b,
   output logic        divreq_val,
   input  logic        divreq_rdy,
   input  logic [63:0] divresp_msg_result,
   input  logic        divresp_val,
   output logic        divresp_rdy,
   output logic        err
);
   logic is_mul, is_div, target_rdy, full, empty, head, push, pop, head_div;
   // request routing: readiness depends on fn and occupancy only, never on val
   always_comb begin
      is_mul = muldivreq_msg_fn == FN_MUL;
      is_div = is_div_fn(muldivreq_msg_fn);
      target_rdy = is_mul ? mulreq_rdy : is_div ? divreq_rdy : 1'b1;
      muldivreq_rdy = !full && target_rdy;
      mulreq_val = muldivreq_val && is_mul && !full;
      divreq_val = muldivreq_val && is_div && !full;
      push = muldivreq_val && muldivreq_rdy && (is_mul || is_div);
   end
   assign mulreq_msg_a = muldivreq_msg_a;
   assign mulreq_msg_b = muldivreq_msg_b;
   assign divreq_msg_a = muldivreq_msg_a;
   assign divreq_msg_b = muldivreq_msg_b;
   assign divreq_msg_fn = is_unsigned_fn(muldivreq_msg_fn) ? DIVFN_UNSIGNED : DIVFN_SIGNED;
   // response steering: only the unit named by the head tag may hand its result over
   always_comb begin
      head_div = head == TAG_DIV;
      muldivresp_val = !empty && (head_div ? divresp_val : mulresp_val);
      muldivresp_msg_result = head_div ? divresp_msg_result : mulresp_msg_result;
      mulresp_rdy = !empty && !head_div && muldivresp_rdy;
      divresp_rdy = !empty && head_div && muldivresp_rdy;
      pop = muldivresp_val && muldivresp_rdy;
   end
   imuldiv_TagFifo #(.DEPTH(DEPTH)) tags (
      .clk(clk),
      .reset(reset),
      .enq_val(push),
      .enq_bits(is_div ? TAG_DIV : TAG_MUL),
      .deq_rdy(pop),
      .full(full),
      .empty(empty),
      .head_bits(head)
   );
   // illegal fn is swallowed on fire and latched until reset
   always_ff @(posedge clk) begin
      if (reset) err <= 1'b0;
      else if (muldivreq_val && muldivreq_rdy && !is_mul && !is_div) err <= 1'b1;
   end
endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// tb_imuldiv_muldiv_dispatch: scoreboard bench with behavioural mul/div unit models
module tb_imuldiv_muldiv_dispatch;
   logic clk = 1'b0, reset;
   logic [2:0] muldivreq_msg_fn;
   logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
   logic muldivreq_val, muldivreq_rdy;
   logic [63:0] muldivresp_msg_result;
   logic muldivresp_val, muldivresp_rdy;
   logic [31:0] mulreq_msg_a, mulreq_msg_b;
   logic mulreq_val, mulreq_rdy;
   logic [63:0] mulresp_msg_result;
   logic mulresp_val, mulresp_rdy;
   logic divreq_msg_fn;
   logic [31:0] divreq_msg_a, divreq_msg_b;
   logic divreq_val, divreq_rdy;
   logic [63:0] divresp_msg_result;
   logic divresp_val, divresp_rdy;
   logic err;

   imuldiv_muldiv_dispatch #(.DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a), .muldivreq_msg_b(muldivreq_msg_b),
      .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
      .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
      .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
      .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
      .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
      .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
      .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
      .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0, resp_cnt = 0;
   logic [63:0] sb[$], mq[$], dq[$], rlog[$];
   logic [63:0] last_resp, s_res;
   logic mresp_en, dresp_en;
   logic req_f, resp_f, mreq_f, dreq_f, mresp_f, dresp_f;
   logic s_rdy, s_val, s_mval, s_mrdy, s_dval, s_drdy, s_mreqval;

   function automatic logic [63:0] exp_res(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb2;
      logic signed [31:0] q, r;
      sa = {{32{a[31]}}, a};
      sb2 = {{32{b[31]}}, b};
      if (fn == 3'd0) return sa * sb2;
      if (fn == 3'd2 || fn == 3'd4) return {a % b, a / b};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
   endfunction

   task automatic cycle();
      mulresp_val = mresp_en && mq.size() > 0;
      mulresp_msg_result = mq.size() > 0 ? mq[0] : 64'h0;
      divresp_val = dresp_en && dq.size() > 0;
      divresp_msg_result = dq.size() > 0 ? dq[0] : 64'h0;
      #1;
      req_f = !reset && muldivreq_val && muldivreq_rdy;
      resp_f = !reset && muldivresp_val && muldivresp_rdy;
      mreq_f = !reset && mulreq_val && mulreq_rdy;
      dreq_f = !reset && divreq_val && divreq_rdy;
      mresp_f = !reset && mulresp_val && mulresp_rdy;
      dresp_f = !reset && divresp_val && divresp_rdy;
      s_rdy = muldivreq_rdy; s_val = muldivresp_val; s_res = muldivresp_msg_result;
      s_mval = mulresp_val; s_mrdy = mulresp_rdy; s_dval = divresp_val; s_drdy = divresp_rdy;
      s_mreqval = mulreq_val;
      if (mreq_f) mq.push_back(exp_res(3'd0, mulreq_msg_a, mulreq_msg_b));
      if (dreq_f) dq.push_back(exp_res(divreq_msg_fn ? 3'd2 : 3'd1, divreq_msg_a, divreq_msg_b));
      if (req_f && muldivreq_msg_fn <= 3'd4) sb.push_back(exp_res(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
      if (resp_f) begin
         checks++;
         resp_cnt++;
         last_resp = muldivresp_msg_result;
         rlog.push_back(muldivresp_msg_result);
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected got=%h exp=none", muldivresp_msg_result);
         end else if (muldivresp_msg_result !== sb[0]) begin
            errors++;
            $display("FAIL resp_data got=%h exp=%h", muldivresp_msg_result, sb[0]);
         end
         if (sb.size() > 0) void'(sb.pop_front());
      end
      if (mresp_f) void'(mq.pop_front());
      if (dresp_f) void'(dq.pop_front());
      if (reset) begin
         mq.delete(); dq.delete(); sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b; muldivreq_val = 1'b1;
      for (int i = 0; i < 50; i++) begin
         cycle();
         if (req_f) break;
      end
      muldivreq_val = 1'b0;
      checks++;
      if (!req_f) begin errors++; $display("FAIL send_timeout got=0 exp=1 fn=%0d", fn); end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() > 0; i++) cycle();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL drain_timeout got=%0d exp=0 pending", sb.size()); end
   endtask

   task automatic test_reset();
      reset = 1'b1; muldivreq_val = 1'b0; muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 0; muldivreq_msg_b = 0;
      mulreq_rdy = 1'b1; divreq_rdy = 1'b1; muldivresp_rdy = 1'b1; mresp_en = 1'b1; dresp_en = 1'b1;
      mulresp_val = 1'b0; divresp_val = 1'b0; mulresp_msg_result = 0; divresp_msg_result = 0;
      repeat (2) @(negedge clk);
      muldivreq_val = 1'b1;
      #1;
      checks += 6;
      if (mulreq_val !== 1'b1) begin errors++; $display("FAIL rst_mulreq_val got=%b exp=1", mulreq_val); end
      if (divreq_val !== 1'b0) begin errors++; $display("FAIL rst_divreq_val got=%b exp=0", divreq_val); end
      if (muldivresp_val !== 1'b0) begin errors++; $display("FAIL rst_resp_val got=%b exp=0", muldivresp_val); end
      if (mulresp_rdy !== 1'b0 || divresp_rdy !== 1'b0) begin errors++; $display("FAIL rst_unit_rdy got=%b%b exp=00", mulresp_rdy, divresp_rdy); end
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
      if (muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL rst_req_rdy got=%b exp=1", muldivreq_rdy); end
      muldivreq_val = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mul();
      muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 3; muldivreq_msg_b = 5; muldivreq_val = 1'b1;
      #1;
      checks += 2;
      if (mulreq_val !== 1'b1) begin errors++; $display("FAIL mul_route_mulval got=%b exp=1", mulreq_val); end
      if (divreq_val !== 1'b0) begin errors++; $display("FAIL mul_route_divval got=%b exp=0", divreq_val); end
      send(3'd0, 3, 5);
      drain();
      checks++;
      if (last_resp !== 64'd15) begin errors++; $display("FAIL mul_result got=%h exp=%h", last_resp, 64'd15); end
   endtask

   task automatic test_div();
      muldivreq_msg_fn = 3'd1; muldivreq_msg_a = -32'sd7; muldivreq_msg_b = 2; muldivreq_val = 1'b1;
      #1;
      checks += 3;
      if (divreq_val !== 1'b1 || mulreq_val !== 1'b0) begin errors++; $display("FAIL div_route got=%b%b exp=10", divreq_val, mulreq_val); end
      if (divreq_msg_fn !== 1'b0) begin errors++; $display("FAIL div_fn got=%b exp=0", divreq_msg_fn); end
      muldivreq_msg_fn = 3'd4;
      #1;
      if (divreq_msg_fn !== 1'b1) begin errors++; $display("FAIL remu_fn got=%b exp=1", divreq_msg_fn); end
      send(3'd1, -32'sd7, 2);
      drain();
      checks++;
      if (last_resp !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_result got=%h exp=FFFFFFFFFFFFFFFD", last_resp); end
   endtask

   task automatic test_out_of_order();
      mresp_en = 1'b1; dresp_en = 1'b0; rlog.delete();
      send(3'd1, 100, 7);
      send(3'd0, 2, 3);
      repeat (3) cycle();
      checks += 2;
      if (s_mval !== 1'b1 || s_mrdy !== 1'b0) begin errors++; $display("FAIL ooo_mul_held got=val%b rdy%b exp=val1 rdy0", s_mval, s_mrdy); end
      if (s_val !== 1'b0) begin errors++; $display("FAIL ooo_resp_val got=%b exp=0", s_val); end
      dresp_en = 1'b1;
      drain();
      checks += 3;
      if (rlog.size() != 2) begin errors++; $display("FAIL ooo_count got=%0d exp=2", rlog.size()); end
      if (rlog[0] !== 64'h00000002_0000000E) begin errors++; $display("FAIL ooo_first got=%h exp=000000020000000E", rlog[0]); end
      if (rlog[1] !== 64'd6) begin errors++; $display("FAIL ooo_second got=%h exp=6", rlog[1]); end
   endtask

   task automatic test_full();
      mresp_en = 1'b0; dresp_en = 1'b0;
      send(3'd0, 4, 4);
      send(3'd1, 9, 3);
      muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 1; muldivreq_msg_b = 1; muldivreq_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks += 2;
         if (req_f !== 1'b0 || s_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got=%b exp=0", s_rdy); end
         if (s_mreqval !== 1'b0) begin errors++; $display("FAIL full_mulreq_val got=%b exp=0", s_mreqval); end
      end
      mresp_en = 1'b1;
      cycle();
      checks++;
      if (resp_f !== 1'b1 || req_f !== 1'b0) begin errors++; $display("FAIL full_nobypass got=pop%b req%b exp=pop1 req0", resp_f, req_f); end
      cycle();
      checks++;
      if (req_f !== 1'b1) begin errors++; $display("FAIL full_accept_after_pop got=%b exp=1", req_f); end
      muldivreq_val = 1'b0;
      dresp_en = 1'b1;
      drain();
   endtask

   task automatic test_hold();
      int n0;
      mresp_en = 1'b1; dresp_en = 1'b1; muldivresp_rdy = 1'b0;
      send(3'd1, 50, 3);
      for (int i = 0; i < 10; i++) begin
         cycle();
         checks += 2;
         if (s_dval !== 1'b1 || s_drdy !== 1'b0) begin errors++; $display("FAIL hold_div got=val%b rdy%b exp=val1 rdy0", s_dval, s_drdy); end
         if (s_val !== 1'b1 || s_res !== 64'h00000002_00000010) begin errors++; $display("FAIL hold_result got=%b/%h exp=1/0000000200000010", s_val, s_res); end
      end
      n0 = resp_cnt;
      muldivresp_rdy = 1'b1;
      repeat (5) cycle();
      checks += 2;
      if (resp_cnt - n0 != 1) begin errors++; $display("FAIL hold_release_fires got=%0d exp=1", resp_cnt - n0); end
      if (s_val !== 1'b0) begin errors++; $display("FAIL hold_empty_after got=%b exp=0", s_val); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] fn;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         fn = 3'($urandom_range(0, 4));
         a = $urandom;
         b = $urandom_range(1, 1000);
         if (i == 0) begin fn = 3'd2; a = 32'hFFFFFFF9; b = 2; end
         if (i == 1) begin fn = 3'd0; a = 32'hFFFFFFFE; b = 9; end
         send(fn, a, b);
      end
      drain();
   endtask

   task automatic test_illegal_and_reset();
      int n0;
      n0 = resp_cnt;
      muldivreq_msg_fn = 3'd6; muldivreq_msg_a = 11; muldivreq_msg_b = 3; muldivreq_val = 1'b1;
      #1;
      checks += 2;
      if (mulreq_val !== 1'b0 || divreq_val !== 1'b0) begin errors++; $display("FAIL ill_unit_val got=%b%b exp=00", mulreq_val, divreq_val); end
      if (muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL ill_rdy got=%b exp=1", muldivreq_rdy); end
      cycle();
      muldivreq_val = 1'b0;
      checks++;
      if (req_f !== 1'b1) begin errors++; $display("FAIL ill_consumed got=%b exp=1", req_f); end
      repeat (3) cycle();
      checks += 2;
      if (err !== 1'b1) begin errors++; $display("FAIL ill_err got=%b exp=1", err); end
      if (resp_cnt != n0 || s_val !== 1'b0) begin errors++; $display("FAIL ill_no_resp got=%0d exp=0", resp_cnt - n0); end
      mresp_en = 1'b0; dresp_en = 1'b0;
      send(3'd0, 7, 7);
      send(3'd3, 20, 6);
      reset = 1'b1;
      repeat (2) cycle();
      reset = 1'b0;
      #1;
      checks += 2;
      if (err !== 1'b0) begin errors++; $display("FAIL rst2_err got=%b exp=0", err); end
      if (muldivresp_val !== 1'b0 || mulresp_rdy !== 1'b0 || divresp_rdy !== 1'b0) begin errors++; $display("FAIL rst2_empty got=%b%b%b exp=000", muldivresp_val, mulresp_rdy, divresp_rdy); end
      mresp_en = 1'b1; dresp_en = 1'b1;
      n0 = resp_cnt;
      repeat (5) cycle();
      checks++;
      if (resp_cnt != n0) begin errors++; $display("FAIL rst2_stale got=%0d exp=0", resp_cnt - n0); end
      send(3'd0, 32'hFFFFFFFE, 9);
      drain();
      checks++;
      if (last_resp !== 64'hFFFFFFFF_FFFFFFEE) begin errors++; $display("FAIL rst2_mul_result got=%h exp=FFFFFFFFFFFFFFEE", last_resp); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_out_of_order();
      test_full();
      test_hold();
      test_back_to_back();
      test_illegal_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
